// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe front end: cell count, cell bit
// positions, the button conditioner state encoding and vector helpers.
package ttt_pkg;

   localparam int CELL_COUNT = 9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      FIRE     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam int CELL_A = 0;
   localparam int CELL_B = 1;
   localparam int CELL_C = 2;
   localparam int CELL_D = 3;
   localparam int CELL_E = 4;
   localparam int CELL_F = 5;
   localparam int CELL_G = 6;
   localparam int CELL_H = 7;
   localparam int CELL_I = 8;

   localparam logic [CELL_COUNT-1:0] CELL_ONE = {{(CELL_COUNT-1){1'b0}}, 1'b1};

   // True when at least two bits of the vector are set.
   function automatic logic is_multi(input logic [CELL_COUNT-1:0] vec);
      return ((vec & (vec - CELL_ONE)) != {CELL_COUNT{1'b0}});
   endfunction

   // True when exactly one bit of the vector is set.
   function automatic logic is_onehot(input logic [CELL_COUNT-1:0] vec);
      return (vec != {CELL_COUNT{1'b0}}) && !is_multi(vec);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two back-to-back capture stages to let metastability settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= {WIDTH{1'b0}};
         r_sync <= {WIDTH{1'b0}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the tic-tac-toe core: synchronises and debounces
// the nine cell buttons, accepts one press at a time and emits a one-hot pulse.
import ttt_pkg::*;

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CELL_COUNT-1:0] btn_raw,
   input  logic                  game_lock,
   output logic [CELL_COUNT-1:0] btn_pulse,
   output logic                  busy,
   output logic                  reject
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]       PCNT_LAST = 8'(PULSE_CYCLES - 1);

   logic [CELL_COUNT-1:0] w_sync_vec;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [7:0]            r_pcnt;
   logic [7:0]            w_pcnt_nxt;
   logic [CELL_COUNT-1:0] r_sel;
   logic [CELL_COUNT-1:0] w_sel_nxt;
   logic [CELL_COUNT-1:0] r_btn_pulse;
   logic [CELL_COUNT-1:0] w_pulse_nxt;
   logic                  r_busy;
   logic                  w_busy_nxt;
   logic                  r_reject;
   logic                  w_reject_nxt;

   sync_2ff #(
      .WIDTH (CELL_COUNT)
   ) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .i_d   (btn_raw),
      .o_q   (w_sync_vec)
   );

   // State, counters, latched cell and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_pcnt      <= 8'd0;
         r_sel       <= {CELL_COUNT{1'b0}};
         r_btn_pulse <= {CELL_COUNT{1'b0}};
         r_busy      <= 1'b0;
         r_reject    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pcnt      <= w_pcnt_nxt;
         r_sel       <= w_sel_nxt;
         r_btn_pulse <= w_pulse_nxt;
         r_busy      <= w_busy_nxt;
         r_reject    <= w_reject_nxt;
      end
   end

   // Next-state, counter updates and next values of the output registers.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_pcnt_nxt   = r_pcnt;
      w_sel_nxt    = r_sel;
      w_reject_nxt = 1'b0;
      w_pulse_nxt  = {CELL_COUNT{1'b0}};
      w_busy_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (is_multi(w_sync_vec)) begin
               // Chorded press: discard it and wait for everything to let go.
               w_state_nxt  = RELEASE;
               w_cnt_nxt    = {CNT_W{1'b0}};
               w_reject_nxt = 1'b1;
            end else if (is_onehot(w_sync_vec) && !game_lock) begin
               w_state_nxt = DEBOUNCE;
               w_sel_nxt   = w_sync_vec;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else if (is_onehot(w_sync_vec)) begin
               // Game over: swallow the press silently.
               w_state_nxt = RELEASE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = IDLE;
            end
         end

         DEBOUNCE: begin
            if (game_lock) begin
               w_state_nxt = RELEASE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else if (w_sync_vec == r_sel) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = FIRE;
                  w_pcnt_nxt  = 8'd0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               // Bounce, release or a second button: start over.
               w_state_nxt = IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end
         end

         FIRE: begin
            // The accepted move always completes, even if the game locks now.
            if (r_pcnt == PCNT_LAST) begin
               w_state_nxt = RELEASE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_pcnt_nxt = r_pcnt + 8'd1;
            end
         end

         RELEASE: begin
            if (w_sync_vec == {CELL_COUNT{1'b0}}) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               w_cnt_nxt = {CNT_W{1'b0}};
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_pcnt_nxt  = 8'd0;
            w_sel_nxt   = {CELL_COUNT{1'b0}};
         end
      endcase

      // Outputs follow the state being entered so they are registered.
      if (w_state_nxt == FIRE) begin
         w_pulse_nxt = w_sel_nxt;
      end else begin
         w_pulse_nxt = {CELL_COUNT{1'b0}};
      end

      if (w_state_nxt != IDLE) begin
         w_busy_nxt = 1'b1;
      end else begin
         w_busy_nxt = 1'b0;
      end
   end

   assign btn_pulse = r_btn_pulse;
   assign busy      = r_busy;
   assign reject    = r_reject;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed, table-driven bench for button_conditioner (D=16; P=1 and P=4).
module tb_button_conditioner;
   import ttt_pkg::*;

   logic       clk;
   logic       rst_n, rst4_n;
   logic [8:0] raw, raw4;
   logic       lock, lock4;
   logic [8:0] pulse, pulse4;
   logic       busy, busy4, rej, rej4;

   int n_checks = 0;
   int n_fail   = 0;

   // per-segment observations
   int         cyc, n_pulse, n_rej, first, n_pulse4, first4;
   logic [8:0] val_or, val_or4;
   int         inv_bad;

   typedef struct packed {
      logic [8:0] raw;
      logic       lock;
      int         cycles;
      int         np;
      logic [8:0] val;
      int         nrej;
      logic       busy;
      int         first;
   } vec_t;

   vec_t tbl [0:63];
   int   ntbl = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(16), .PULSE_CYCLES(1)) dut (
      .clk(clk), .reset(rst_n), .btn_raw(raw), .game_lock(lock),
      .btn_pulse(pulse), .busy(busy), .reject(rej));

   button_conditioner #(.DEBOUNCE_CYCLES(16), .PULSE_CYCLES(4)) dut4 (
      .clk(clk), .reset(rst4_n), .btn_raw(raw4), .game_lock(lock4),
      .btn_pulse(pulse4), .busy(busy4), .reject(rej4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clr();
      cyc = 0; n_pulse = 0; n_rej = 0; first = 0; val_or = 9'h000;
      n_pulse4 = 0; first4 = 0; val_or4 = 9'h000; inv_bad = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (pulse != 9'h000) begin
         n_pulse++;
         val_or |= pulse;
         if (first == 0) first = cyc;
         if ((pulse & (pulse - 9'h001)) != 9'h000) inv_bad++;
         if (rej) inv_bad++;
      end
      if (rej) n_rej++;
      if (pulse4 != 9'h000) begin
         n_pulse4++;
         val_or4 |= pulse4;
         if (first4 == 0) first4 = cyc;
         if ((pulse4 & (pulse4 - 9'h001)) != 9'h000) inv_bad++;
         if (rej4) inv_bad++;
      end
   endtask

   task automatic add(input logic [8:0] r, input logic l, input int c, input int np,
                      input logic [8:0] v, input int nr, input logic b, input int f);
      tbl[ntbl] = '{raw: r, lock: l, cycles: c, np: np, val: v, nrej: nr, busy: b, first: f};
      ntbl++;
   endtask

   initial begin
      logic [8:0] v;
      rst_n = 1'b0; rst4_n = 1'b0;
      raw = 9'h000; raw4 = 9'h000; lock = 1'b0; lock4 = 1'b0;
      clr();

      // ---------------- vector table ----------------
      // raw      lock  cyc np val     rej busy first
      add(9'h010, 1'b0, 40, 1, 9'h010, 0, 1'b1, 19);  // clean press
      add(9'h000, 1'b0, 10, 0, 9'h000, 0, 1'b1, 0);   // release not yet debounced
      add(9'h000, 1'b0, 10, 0, 9'h000, 0, 1'b0, 0);   // release accepted
      add(9'h003, 1'b0,  5, 0, 9'h000, 1, 1'b1, 0);   // multi-press
      add(9'h001, 1'b0, 30, 0, 9'h000, 0, 1'b1, 0);   // narrow to one, no release
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h001, 1'b0, 25, 1, 9'h001, 0, 1'b1, 19);  // fresh press after release
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h100, 1'b1, 30, 0, 9'h000, 0, 1'b1, 0);   // locked press
      add(9'h100, 1'b0, 30, 0, 9'h000, 0, 1'b1, 0);   // lock dropped mid-hold
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h100, 1'b0, 25, 1, 9'h100, 0, 1'b1, 19);  // re-press after unlock
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h004, 1'b0, 10, 0, 9'h000, 0, 1'b1, 0);   // mid-debounce
      add(9'h004, 1'b1, 20, 0, 9'h000, 0, 1'b1, 0);   // lock during debounce
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h0C0, 1'b1,  5, 0, 9'h000, 1, 1'b1, 0);   // multi-press while locked
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      add(9'h020, 1'b0, 200, 1, 9'h020, 0, 1'b1, 19); // long hold, single pulse
      add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      for (int c = CELL_A; c <= CELL_I; c++) begin
         v = 9'h001 << c;
         add(v, 1'b0, 25, 1, v, 0, 1'b1, 19);
         add(9'h000, 1'b0, 20, 0, 9'h000, 0, 1'b0, 0);
      end

      // ---------------- reset state ----------------
      #23;
      check("reset_pulse", int'(pulse), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_reject", int'(rej), 0);
      check("reset_pulse4", int'(pulse4), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; rst4_n = 1'b1;
      for (int k = 0; k < 3; k++) step();
      check("idle_busy", int'(busy), 0);

      // ---------------- table loop ----------------
      for (int i = 0; i < ntbl; i++) begin
         raw = tbl[i].raw; lock = tbl[i].lock;
         clr();
         for (int k = 0; k < tbl[i].cycles; k++) step();
         check($sformatf("row%0d_npulse", i), n_pulse, tbl[i].np);
         check($sformatf("row%0d_value", i), int'(val_or), int'(tbl[i].val));
         check($sformatf("row%0d_reject", i), n_rej, tbl[i].nrej);
         check($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].busy));
         check($sformatf("row%0d_invariant", i), inv_bad, 0);
         if (tbl[i].np > 0) check($sformatf("row%0d_latency", i), first, tbl[i].first);
      end

      // ---------------- bounce then steady hold ----------------
      raw = 9'h000; lock = 1'b0;
      clr();
      for (int k = 0; k < 30; k++) begin
         raw = ((k / 3) % 2 == 0) ? 9'h001 : 9'h000;
         step();
      end
      check("bounce_no_pulse", n_pulse, 0);
      raw = 9'h001;
      clr();
      for (int k = 0; k < 30; k++) step();
      check("bounce_hold_npulse", n_pulse, 1);
      check("bounce_hold_value", int'(val_or), 9'h001);
      check("bounce_hold_latency", first, 19);
      raw = 9'h000;
      for (int k = 0; k < 20; k++) step();

      // ---------------- reset mid-FIRE (P=4) ----------------
      raw4 = 9'h010;
      clr();
      for (int k = 0; k < 40 && n_pulse4 < 2; k++) step();
      check("rst_fire_reached", n_pulse4, 2);
      rst4_n = 1'b0;
      #1;
      check("rst_fire_pulse_cut", int'(pulse4), 0);
      check("rst_fire_busy_cut", int'(busy4), 0);
      @(posedge clk); @(posedge clk); #1;
      rst4_n = 1'b1;
      clr();
      for (int k = 0; k < 40; k++) step();
      check("rst_refire_npulse", n_pulse4, 4);
      check("rst_refire_value", int'(val_or4), 9'h010);
      check("rst_refire_latency", first4, 19);
      check("rst_refire_invariant", inv_bad, 0);

      // ---------------- lock rising during FIRE (P=4) ----------------
      raw4 = 9'h000;
      for (int k = 0; k < 20; k++) step();
      check("p4_idle_busy", int'(busy4), 0);
      raw4 = 9'h002;
      clr();
      for (int k = 0; k < 40; k++) begin
         step();
         if (pulse4 != 9'h000) lock4 = 1'b1;
      end
      check("lock_fire_npulse", n_pulse4, 4);
      check("lock_fire_value", int'(val_or4), 9'h002);
      check("lock_fire_reject", int'(rej4), 0);
      lock4 = 1'b0; raw4 = 9'h000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
